// File: rtl/window_pkg.sv
// Shared widths and window layout for the 5x5 neighbourhood generator.
// Latency: none, because this package holds only types, constants and a helper function.
// Backpressure: not applicable.
package window_pkg;

    localparam int PIX_W   = 8;
    localparam int WIN_DIM = 5;
    localparam int WIN_W   = PIX_W * WIN_DIM * WIN_DIM;

    // Index [r][c] lands at bit 40r+8c: row 0 is the top line, column 0 the oldest pixel.
    typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] win_t;
    typedef logic [WIN_DIM-1:0][PIX_W-1:0]              win_col_t;

    function automatic int win_bit_offset(input int r, input int c);
        return PIX_W * (WIN_DIM * r + c);
    endfunction

endpackage

// File: rtl/window_5x5_generator_line_buffer.sv
// One image line of pixel storage, addressed by column.
// Latency: the read is combinational and the write takes effect at the next rising edge.
// Backpressure: none; the owner gates we.
module line_buffer
    import window_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_5x5_generator.sv
// Streams raster pixels in and emits one 5x5 window per interior pixel; SOF_SYNC_EN adds in_sof resync.
// Latency: win_valid rises 1 cycle after the qualifying pixel is accepted.
// Backpressure: in_ready = !win_valid || win_ready, and the window holds while it is stalled.
module window_5x5_generator
    import window_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [WIN_W-1:0] win_data,
    output logic             win_last
`ifdef SOF_SYNC_EN
    ,
    input  logic             in_sof
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN_DIM - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_DIM - 1);
    localparam int NUM_LB = WIN_DIM - 1;

    logic [CW-1:0]    col, cur_col;
    logic [RW-1:0]    row, cur_row;
    logic             sof, accept, qualify, frame_end;
    logic [PIX_W-1:0] lb_rd [NUM_LB];
    win_col_t         new_col;
    win_t             win;

`ifdef SOF_SYNC_EN
    assign sof = in_sof;
`else
    assign sof = 1'b0;
`endif

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame pixel is treated as (0,0) regardless of where the counters are.
    assign cur_col   = sof ? '0 : col;
    assign cur_row   = sof ? '0 : row;
    assign qualify   = (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
    assign frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    always_comb begin
        new_col = '0;
        for (int k = 0; k < NUM_LB; k++) begin
            new_col[k] = lb_rd[k];
        end
        new_col[WIN_DIM-1] = in_data;
    end

    // Each buffer takes the line below it, so the stack moves up one line per column visit.
    for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
        line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (cur_col),
            .wdata (new_col[i+1]),
            .rdata (lb_rd[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    // Accepting a pixel implies the current window is consumed or absent, so shifting is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (accept) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                win[r] <= {new_col[r], win[r][WIN_DIM-1:1]};
            end
            win_valid <= qualify;
            win_last  <= qualify && frame_end;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

    assign win_data = win;

endmodule

// File: tb/tb_window_5x5_generator.sv
// Bench for window_5x5_generator on an 8x8 image, checked against an image-level window model.
// Build with SOF_SYNC_EN to add the start-of-frame resync scenario.
module tb_window_5x5_generator;
    import window_pkg::*;

    localparam int W = 8;
    localparam int H = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_data;
    logic             win_valid;
    logic             win_ready = 1'b1;
    logic [WIN_W-1:0] win_data;
    logic             win_last;
`ifdef SOF_SYNC_EN
    logic             in_sof = 1'b0;
`endif

    window_5x5_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
`ifdef SOF_SYNC_EN
        .in_sof    (in_sof),
`endif
        .win_last  (win_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIN_W-1:0] data;
        logic             last;
    } win_rec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    win_rec_t    got_q[$];
    win_rec_t    exp_q[$];
    logic [7:0]  img [H][W];
    int          rdy_mode   = 0;
    int          stall_left = 0;
    bit          stall_arm  = 1'b0;

    // Downstream: random or always-ready, with an optional 5-cycle stall on the next window.
    always begin
        @(posedge clk);
        #1;
        if (stall_arm && win_valid) begin
            stall_arm  = 1'b0;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            win_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            win_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        if (!rst && win_valid && win_ready) begin
            got_q.push_back('{win_data, win_last});
        end
    end

    task automatic fill_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'(W * r + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom_range(0, 255));
    endtask

    // Every interior position yields the 5x5 block of the image ending at that pixel.
    task automatic model_frame();
        win_rec_t rec;
        for (int r = WIN_DIM - 1; r < H; r++) begin
            for (int c = WIN_DIM - 1; c < W; c++) begin
                rec.data = '0;
                for (int i = 0; i < WIN_DIM; i++)
                    for (int j = 0; j < WIN_DIM; j++)
                        rec.data[win_bit_offset(i, j) +: PIX_W] = img[r-WIN_DIM+1+i][c-WIN_DIM+1+j];
                rec.last = (r == H - 1) && (c == W - 1);
                exp_q.push_back(rec);
            end
        end
    endtask

    task automatic send_pix(input logic [7:0] d, input bit sof, input int gap_pct);
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
`ifdef SOF_SYNC_EN
        in_sof = sof;
`endif
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) return;
            @(posedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_pix_timeout: in_ready=%b after 200 cycles, required 1", in_ready);
    endtask

    task automatic send_frame(input bit sof_first, input int gap_pct);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pix(img[r][c], sof_first && r == 0 && c == 0, gap_pct);
    endtask

    task automatic idle_and_drain();
        @(posedge clk);
        #1 in_valid = 1'b0;
`ifdef SOF_SYNC_EN
        in_sof = 1'b0;
`endif
        for (int k = 0; k < 400 && got_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        n_tests++;
        if (win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_win_valid_during: got %b required 0", win_valid);
        end
        apply_reset();
        @(negedge clk);
        n_tests++;
        if (win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_win_valid: got %b required 0", win_valid);
        end
        n_tests++;
        if (win_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_win_last: got %b required 0", win_last);
        end
        n_tests++;
        if (win_data !== '0) begin
            n_fail++;
            $display("FAIL reset_win_data: got %h required 0", win_data);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_ramp();
        logic [WIN_W-1:0] w;
        rdy_mode = 0;
        fill_ramp();
        model_frame();
        send_frame(1'b0, 0);
        idle_and_drain();
        n_tests++;
        if (got_q.size() != 16) begin
            n_fail++;
            $display("FAIL ramp_count: got %0d windows, required 16", got_q.size());
        end
        if (got_q.size() >= 16) begin
            w = got_q[0].data;
            n_tests++;
            if (w[7:0] !== 8'd0 || w[199:192] !== 8'd36) begin
                n_fail++;
                $display("FAIL ramp_first: byte0=%0d byte24=%0d, required 0 and 36", w[7:0], w[199:192]);
            end
            w = got_q[15].data;
            n_tests++;
            if (w[7:0] !== 8'd27 || w[199:192] !== 8'd63 || got_q[15].last !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp_last: byte0=%0d byte24=%0d last=%b, required 27 63 1", w[7:0], w[199:192], got_q[15].last);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL ramp_win[%0d]: got %h last %b, required %h last %b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIN_W-1:0] saved;
        int found;
        got_q.delete();
        exp_q.delete();
        rdy_mode = 0;
        fill_ramp();
        model_frame();
        stall_arm = 1'b1;
        fork
            send_frame(1'b0, 0);
            begin
                found = 0;
                for (int k = 0; k < 300 && found == 0; k++) begin
                    @(negedge clk);
                    if (win_valid && !win_ready) found = 1;
                end
                n_tests++;
                if (found == 0) begin
                    n_fail++;
                    $display("FAIL bp_stall_seen: no stalled window within 300 cycles, required one");
                end else begin
                    saved = win_data;
                    for (int s = 0; s < 5; s++) begin
                        if (s > 0) @(negedge clk);
                        n_tests++;
                        if (in_ready !== 1'b0 || win_valid !== 1'b1 || win_data !== saved) begin
                            n_fail++;
                            $display("FAIL bp_hold[%0d]: in_ready=%b win_valid=%b data %h, required 0 1 %h", s, in_ready, win_valid, win_data, saved);
                        end
                    end
                end
            end
        join
        idle_and_drain();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL bp_win[%0d]: got %h last %b, required %h last %b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIN_W-1:0] w;
        got_q.delete();
        exp_q.delete();
        rdy_mode = 0;
        fill_ramp();
        model_frame();
        model_frame();
        send_frame(1'b0, 0);
        send_frame(1'b0, 0);
        idle_and_drain();
        n_tests++;
        if (got_q.size() != 32) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d windows, required 32", got_q.size());
        end
        if (got_q.size() > 16) begin
            w = got_q[16].data;
            n_tests++;
            if (w[7:0] !== 8'd0 || w[199:192] !== 8'd36) begin
                n_fail++;
                $display("FAIL b2b_second_first: byte0=%0d byte24=%0d, required 0 and 36", w[7:0], w[199:192]);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL b2b_win[%0d]: got %h last %b, required %h last %b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        rdy_mode = 1;
        fill_random();
        for (int p = 0; p < 30; p++) send_pix(img[p / W][p % W], 1'b0, 0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_win_valid: got %b required 0", win_valid);
        end
        apply_reset();
        rdy_mode = 0;
        fill_ramp();
        model_frame();
        send_frame(1'b0, 0);
        idle_and_drain();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rst_mid_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL rst_mid_win[%0d]: got %h last %b, required %h last %b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask

    task automatic test_random();
        got_q.delete();
        exp_q.delete();
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            model_frame();
            send_frame(1'b0, 25);
        end
        idle_and_drain();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL rand_win[%0d]: got %h last %b, required %h last %b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
        rdy_mode = 0;
    endtask

`ifdef SOF_SYNC_EN
    task automatic test_sof_resync();
        got_q.delete();
        exp_q.delete();
        rdy_mode = 0;
        for (int p = 0; p < 13; p++) send_pix(8'($urandom_range(0, 255)), 1'b0, 0);
        fill_ramp();
        model_frame();
        send_frame(1'b1, 0);
        idle_and_drain();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL sof_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
                n_fail++;
                $display("FAIL sof_win[%0d]: got %h last %b, required %h last %b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
`ifdef SOF_SYNC_EN
        test_sof_resync();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
